// File: rtl/chi_pkg.sv
// CHI link-layer shared definitions for the HN-F receive channels.
// Holds flit layouts, per-channel widths, TgtID offsets and credit defaults.
package chi_pkg;

    localparam int NODE_ID_W = 7;

    // Every flit starts with QoS[3:0] followed by TgtID.
    typedef struct packed {
        logic [66:0]          body;
        logic [NODE_ID_W-1:0] tgtid;
        logic [3:0]           qos;
    } reqflit_t;

    typedef struct packed {
        logic [37:0]          body;
        logic [NODE_ID_W-1:0] tgtid;
        logic [3:0]           qos;
    } rspflit_t;

    typedef struct packed {
        logic [296:0]         body;
        logic [NODE_ID_W-1:0] tgtid;
        logic [3:0]           qos;
    } datflit_t;

    localparam int REQ_FLIT_W = $bits(reqflit_t);
    localparam int RSP_FLIT_W = $bits(rspflit_t);
    localparam int DAT_FLIT_W = $bits(datflit_t);

    localparam int REQ_TGTID_LSB = 4;
    localparam int RSP_TGTID_LSB = 4;
    localparam int DAT_TGTID_LSB = 4;

    // numCreditsForHN defaults per receive channel.
    localparam int HN_REQ_CRD = 15;
    localparam int HN_RSP_CRD = 15;
    localparam int HN_DAT_CRD = 15;

endpackage

// File: rtl/chi_rx_queue.sv
// In-order FIFO with arbitrary DEPTH and asynchronous active-low reset.
// Ports: wr_en/wr_data push, rd_en pops head rd_data; count/empty/full status.
module chi_rx_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr, do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    // Stale slots never leak out once the queue drains.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr_en && full && !rd_en))
                else $error("chi_rx_queue: write while full dropped");
        end
    end

endmodule

// File: rtl/hnf_rxchan.sv
// CHI link-layer receive channel: issues L-credits, queues flits, flags errors.
// Ports: RXFLIT/RXFLITV/RXLCRDV link side, deq_* consumer side, status/errors.
module hnf_rxchan
    import chi_pkg::*;
#(
    parameter int                   FLIT_W    = 64,
    parameter int                   DEPTH     = 8,
    parameter int                   MAX_CRD   = 15,
    parameter int                   TGTID_LSB = 4,
    parameter logic [NODE_ID_W-1:0] NODE_ID   = 7'h0,
    parameter bit                   TGT_CHECK = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [FLIT_W-1:0]          RXFLIT,
    input  logic                       RXFLITV,
    input  logic                       RXFLITPEND,
    output logic                       RXLCRDV,
    output logic [FLIT_W-1:0]          deq_flit,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [3:0]                 crd_out,
    output logic                       err_nocrd,
    output logic                       err_tgt,
    input  logic                       err_clr
);

    localparam int CW = $clog2(DEPTH+1);

    logic          lcrd_q, lcrd_d;
    logic [3:0]    crd_q, crd_d;
    logic          err_nocrd_q, err_nocrd_d;
    logic          err_tgt_q, err_tgt_d;
    logic [CW-1:0] occ_d;
    logic          tgt_ok, consume, accept, pop, empty, full;
    logic          unused_pend;

    assign unused_pend = RXFLITPEND;

    assign tgt_ok = !TGT_CHECK ||
                    (RXFLIT[TGTID_LSB +: NODE_ID_W] == NODE_ID);
    // A credited flit spends its credit even if the TgtID check drops it.
    assign consume = RXFLITV & (crd_q != 4'd0);
    assign accept  = consume & tgt_ok;
    assign pop     = deq_valid & deq_ready;

    chi_rx_queue #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clock),
        .rst_n   (reset),
        .wr_en   (accept),
        .wr_data (RXFLIT),
        .rd_en   (pop),
        .rd_data (deq_flit),
        .count   (occupancy),
        .empty   (empty),
        .full    (full)
    );

    assign deq_valid = ~empty;

    always_comb begin
        occ_d = occupancy
              + CW'(accept & (~full | pop))
              - CW'(pop);
        crd_d = crd_q + 4'(lcrd_q) - 4'(consume);
        // Next grant keeps crd_out + occupancy within DEPTH.
        lcrd_d = ((int'(crd_d) + int'(occ_d)) < DEPTH) &&
                 (int'(crd_d) < MAX_CRD);
        err_nocrd_d = (RXFLITV & (crd_q == 4'd0)) |
                      (err_nocrd_q & ~err_clr);
        err_tgt_d   = (consume & ~tgt_ok) |
                      (err_tgt_q & ~err_clr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lcrd_q      <= 1'b0;
            crd_q       <= 4'd0;
            err_nocrd_q <= 1'b0;
            err_tgt_q   <= 1'b0;
        end else begin
            lcrd_q      <= lcrd_d;
            crd_q       <= crd_d;
            err_nocrd_q <= err_nocrd_d;
            err_tgt_q   <= err_tgt_d;
        end
    end

    assign RXLCRDV   = lcrd_q;
    assign crd_out   = crd_q;
    assign err_nocrd = err_nocrd_q;
    assign err_tgt   = err_tgt_q;

endmodule
